lpddr5_rd_responder: RTL and testbench
======================================

LPDDR5_RD_RESPONDER -- requirements
Module: lpddr5_rd_responder

Interface
REQ-001 Parameter DATA_SIZE, default 15, read/write data width in bits.
REQ-002 Parameter ADDR_W, default 4, address width; storage depth is 2**ADDR_W words.
REQ-003 Parameter RL, default 6, read latency in cycles from command acceptance to response-FIFO entry; legal range 1..15.
REQ-004 Parameter DEPTH, default 4, response FIFO depth and credit limit; power of two, 2..8.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 wr_en  input  1  write strobe.
REQ-008 wr_addr  input  ADDR_W  write address.
REQ-009 wr_data  input  DATA_SIZE  write data.
REQ-010 cmd_valid  input  1  read command from initiator is valid.
REQ-011 cmd_ready  output  1  responder accepts the command this cycle.
REQ-012 cmd_addr  input  ADDR_W  read address.
REQ-013 rsp_valid  output  1  response data is valid.
REQ-014 rsp_ready  input  1  initiator accepts the response this cycle.
REQ-015 rsp_data  output  DATA_SIZE  read data.
REQ-016 busy  output  1  at least one command is in flight or a response is queued.

Function
REQ-017 A command SHALL be accepted exactly in cycles where cmd_valid and cmd_ready are both high.
REQ-018 On acceptance, the data SHALL be sampled write-first: if wr_en is high and wr_addr equals cmd_addr in the same cycle, the response data SHALL be wr_data; otherwise it SHALL be the stored word.
REQ-019 Sampled data SHALL travel through an RL-stage valid/data delay line and enter the response FIFO exactly RL cycles after acceptance.
REQ-020 The response FIFO SHALL present its head on rsp_data with rsp_valid high while it is non-empty; when rsp_valid is high, rsp_data SHALL be held stable until rsp_ready is high.
REQ-021 A pop SHALL occur when rsp_valid and rsp_ready are both high; a push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-022 Credit rule: outstanding = in-flight stages + FIFO occupancy; cmd_ready SHALL be high if and only if outstanding < DEPTH, evaluated from registered state, so that a same-cycle pop does not raise cmd_ready.
REQ-023 Because of REQ-022, the FIFO SHALL never overflow; a push while full is unreachable and SHALL be covered by an assertion.
REQ-024 Responses SHALL be returned in command-acceptance order, with no loss and no duplication.
REQ-025 Writes SHALL update storage on the clock edge, independently of the read path; writes do not alter data already sampled.
REQ-026 busy SHALL equal (outstanding != 0).
REQ-027 Occupancy and pointer counters SHALL use modular wrap-around on pointers of log2(DEPTH) bits, with one extra bit for the full/empty distinction.
REQ-028 Peak throughput SHALL be one command per cycle while credits are available and rsp_ready is held high.

Reset
REQ-029 While rst_n is low: cmd_ready=0, rsp_valid=0, rsp_data=0, busy=0; delay line and FIFO cleared; storage cleared to 0.
REQ-030 cmd_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight and queued responses, with no response emitted after release.

Structure
REQ-032 Default values of DATA_SIZE, ADDR_W, RL and DEPTH SHALL be constants in lpddr5_agt_params_pkg.
REQ-033 The response FIFO SHALL be the sub-module lpddr5_rsp_fifo (parameters DATA_SIZE, DEPTH; push/pop/full/empty/count); all other logic stays in the top level.

Verification
REQ-034 Write addr 3 = 0x1234; read addr 3 with rsp_ready=1 -> rsp_valid asserted exactly RL=6 cycles after acceptance, rsp_data=0x1234.
REQ-035 Same-cycle write addr 5 = 0x0AAA and read addr 5 -> response 0x0AAA.
REQ-036 rsp_ready=0, 6 back-to-back commands -> exactly 4 accepted, cmd_ready low from the 5th; raise rsp_ready -> 4 responses in order, then cmd_ready high again.
REQ-037 Stream of 20 reads to addresses 0..15,0..3 with rsp_ready toggled pseudo-randomly -> ordered, lossless data; never more than 4 outstanding.
REQ-038 Assert rst_n low 3 cycles after 2 accepted commands -> outputs at reset values, no response after release, busy=0.

Source files
------------

// File: rtl/lpddr5_agt_params_pkg.sv
// Shared defaults and helpers for the LPDDR5 read responder slice.
//   DATA_SIZE_DEF : read/write data width in bits
//   ADDR_W_DEF    : address width, storage holds 2**ADDR_W words
//   RL_DEF        : read latency from command acceptance to response-FIFO entry
//   DEPTH_DEF     : response FIFO depth, also the command credit limit
package lpddr5_agt_params_pkg;

    localparam int unsigned DATA_SIZE_DEF = 15;
    localparam int unsigned ADDR_W_DEF    = 4;
    localparam int unsigned RL_DEF        = 6;
    localparam int unsigned DEPTH_DEF     = 4;

    // Pointer width for a power-of-two FIFO: index bits plus one wrap bit
    // so that full and empty can be told apart.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/lpddr5_rd_responder_if.sv
// Bus bundle between a read initiator and the LPDDR5 read responder.
//   wr_en/wr_addr/wr_data   : storage write port (initiator -> responder)
//   cmd_valid/cmd_ready     : read command handshake, cmd_addr is the address
//   rsp_valid/rsp_ready     : response handshake, rsp_data is the read data
//   busy                    : responder has commands in flight or queued
interface lpddr5_rd_responder_if
    import lpddr5_agt_params_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF
);

    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_SIZE-1:0] wr_data;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [ADDR_W-1:0]    cmd_addr;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DATA_SIZE-1:0] rsp_data;
    logic                 busy;

    modport master (
        output wr_en, wr_addr, wr_data, cmd_valid, cmd_addr, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, cmd_valid, cmd_addr, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, busy
    );

endinterface

// File: rtl/lpddr5_rsp_fifo.sv
// Response FIFO for the LPDDR5 read responder.
//   clk, rst_n   : clock, asynchronous active-low reset (clears pointers and storage)
//   push/push_data : enqueue one word
//   pop          : dequeue the head word (caller only pops when non-empty)
//   head_data    : current head word
//   full/empty   : occupancy flags
//   count        : occupancy, pointer-difference with wrap bit
module lpddr5_rsp_fifo
    import lpddr5_agt_params_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_SIZE-1:0]     push_data,
    input  logic                     pop,
    output logic [DATA_SIZE-1:0]     head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = ptr_width(DEPTH);

    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [DATA_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        count     = wr_ptr - rd_ptr;
        full      = (count == PW'(DEPTH));
        empty     = (count == '0);
        head_data = mem[rd_ptr[AW-1:0]];
    end

    // Credit accounting upstream makes both of these unreachable.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && full));
            assert (!(pop && empty));
        end
    end

endmodule

// File: rtl/lpddr5_rd_responder.sv
// LPDDR5 read responder: small write-first storage array, fixed-latency read
// delay line and a credit-limited response FIFO.
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset, clears storage, delay line and FIFO
//   bus   : slave side of lpddr5_rd_responder_if (write port, read command,
//           read response and busy)
module lpddr5_rd_responder
    import lpddr5_agt_params_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned RL        = RL_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    lpddr5_rd_responder_if.slave  bus
);

    localparam int unsigned CW    = ptr_width(DEPTH);
    localparam int unsigned OW    = $clog2(RL + DEPTH + 1);
    localparam int unsigned WORDS = 2 ** ADDR_W;

    logic [DATA_SIZE-1:0] mem [WORDS];
    logic [RL-1:0]        dl_valid;
    logic [DATA_SIZE-1:0] dl_data [RL];

    logic                 accept;
    logic [DATA_SIZE-1:0] sampled;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic [DATA_SIZE-1:0] fifo_head;
    logic [OW-1:0]        inflight;
    logic [OW-1:0]        outstanding;
    logic                 cmd_ready;
    logic                 rsp_valid;

    // Storage write port, independent of the read path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Write-first sampling: a same-cycle write to the read address wins.
    always_comb begin
        sampled = mem[bus.cmd_addr];
        if (bus.wr_en && (bus.wr_addr == bus.cmd_addr)) begin
            sampled = bus.wr_data;
        end
    end

    // RL-stage delay line; the last stage feeds the FIFO push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_valid <= '0;
            for (int unsigned i = 0; i < RL; i++) begin
                dl_data[i] <= '0;
            end
        end else begin
            dl_valid[0] <= accept;
            dl_data[0]  <= sampled;
            for (int unsigned i = 1; i < RL; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_data[i]  <= dl_data[i-1];
            end
        end
    end

    // Credits come only from registered state, so a pop in this cycle
    // frees its credit one cycle later.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RL; i++) begin
            inflight = inflight + OW'(dl_valid[i]);
        end
        outstanding = inflight + OW'(fifo_count);
        cmd_ready   = rst_n && (outstanding < OW'(DEPTH));
        accept      = bus.cmd_valid && cmd_ready;
        rsp_valid   = !fifo_empty;
        pop         = rsp_valid && bus.rsp_ready;
        push        = dl_valid[RL-1];
    end

    lpddr5_rsp_fifo #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (dl_data[RL-1]),
        .pop       (pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A full FIFO must have consumed every credit.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(fifo_full && (inflight != '0)));
        end
    end

    always_comb begin
        bus.cmd_ready = cmd_ready;
        bus.rsp_valid = rsp_valid;
        bus.rsp_data  = fifo_head;
        bus.busy      = (outstanding != '0);
    end

endmodule

// File: tb/tb_lpddr5_rd_responder.sv
// Self-checking bench for lpddr5_rd_responder: directed scenarios plus a
// randomized phase, all checked cycle by cycle against a queue-based model.
module tb_lpddr5_rd_responder;
    import lpddr5_agt_params_pkg::*;

    localparam int unsigned DS  = DATA_SIZE_DEF;
    localparam int unsigned AW  = ADDR_W_DEF;
    localparam int unsigned LAT = RL_DEF;
    localparam int unsigned DEP = DEPTH_DEF;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lpddr5_rd_responder_if #(.DATA_SIZE(DS), .ADDR_W(AW)) bus ();

    lpddr5_rd_responder #(
        .DATA_SIZE (DS),
        .ADDR_W    (AW),
        .RL        (LAT),
        .DEPTH     (DEP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [DS-1:0] d;
        int            due;
    } pend_t;

    // Reference model: responses waiting for their latency, then queued.
    pend_t         pend[$];
    logic [DS-1:0] rspq[$];
    logic [DS-1:0] m_mem [2**AW];
    logic [DS-1:0] popped[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int dut_acc = 0;
    int dut_pop = 0;
    int max_out = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model,
    // then return just after the rising edge for the caller to drive.
    task automatic cycle();
        pend_t         p;
        int            outst;
        logic          e_ready, e_valid, acc, pop;
        logic [DS-1:0] d;
        @(negedge clk);
        if (!rst_n) begin
            check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check_eq("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
            check_eq("rst_busy",      32'(bus.busy),      32'd0);
            pend.delete();
            rspq.delete();
            foreach (m_mem[i]) m_mem[i] = '0;
            dut_acc = 0;
            dut_pop = 0;
        end else begin
            outst   = pend.size() + rspq.size();
            e_ready = (outst < int'(DEP));
            e_valid = (rspq.size() != 0);
            check_eq("cmd_ready", 32'(bus.cmd_ready), 32'(e_ready));
            check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(e_valid));
            check_eq("busy",      32'(bus.busy),      32'(outst != 0));
            if (e_valid) check_eq("rsp_data", 32'(bus.rsp_data), 32'(rspq[0]));

            if (bus.cmd_valid && bus.cmd_ready) dut_acc++;
            if (bus.rsp_valid && bus.rsp_ready) begin
                dut_pop++;
                popped.push_back(bus.rsp_data);
            end
            if (dut_acc - dut_pop > max_out) max_out = dut_acc - dut_pop;

            acc = bus.cmd_valid && e_ready;
            pop = e_valid && bus.rsp_ready;
            if (acc) begin
                d = (bus.wr_en && bus.wr_addr == bus.cmd_addr) ? bus.wr_data : m_mem[bus.cmd_addr];
                p.d   = d;
                p.due = cyc + int'(LAT);
                pend.push_back(p);
            end
            if (pop) void'(rspq.pop_front());
            if (bus.wr_en) m_mem[bus.wr_addr] = bus.wr_data;
            while (pend.size() != 0 && pend[0].due == cyc) begin
                p = pend.pop_front();
                rspq.push_back(p.d);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        idle_inputs();
        bus.rsp_ready = 1'b1;
        while (bus.busy && n < 100) begin
            cycle();
            n++;
        end
        check_eq(tag, 32'(bus.busy), 32'd0);
    endtask

    logic [DS-1:0] wv [2**AW];
    logic [DS-1:0] w36 [6];

    initial begin
        int n, p0, a0, idx;
        logic acc;

        rst_n = 1'b0;
        idle_inputs();
        bus.rsp_ready = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
        #1;
        check_eq("ready_after_rst", 32'(bus.cmd_ready), 32'd1);
        cycle();

        // Write then read, checking the acceptance-to-valid latency.
        bus.wr_en = 1'b1; bus.wr_addr = AW'(3); bus.wr_data = DS'(16'h1234);
        cycle();
        idle_inputs();
        bus.cmd_valid = 1'b1; bus.cmd_addr = AW'(3); bus.rsp_ready = 1'b1;
        cycle();
        idle_inputs();
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            cycle();
            n++;
        end
        check_eq("lat_rl", 32'(n), 32'(LAT));
        check_eq("lat_data", 32'(bus.rsp_data), 32'h1234);
        drain("drain_lat");

        // Same-cycle write and read of one address returns the new data.
        bus.wr_en = 1'b1; bus.wr_addr = AW'(5); bus.wr_data = DS'(16'h0AAA);
        bus.cmd_valid = 1'b1; bus.cmd_addr = AW'(5);
        cycle();
        drain("drain_wf");
        check_eq("write_first", 32'(popped[popped.size()-1]), 32'h0AAA);

        // Credit limit with the response side stalled.
        for (int i = 0; i < 6; i++) begin
            w36[i] = DS'(16'h100 + i * 16'h11);
            bus.wr_en = 1'b1; bus.wr_addr = AW'(8 + i); bus.wr_data = w36[i];
            cycle();
        end
        idle_inputs();
        bus.rsp_ready = 1'b0;
        a0 = dut_acc;
        for (int i = 0; i < 6; i++) begin
            bus.cmd_valid = 1'b1; bus.cmd_addr = AW'(8 + i);
            cycle();
        end
        check_eq("credit_accepts", 32'(dut_acc - a0), 32'(DEP));
        check_eq("credit_ready_low", 32'(bus.cmd_ready), 32'd0);
        idle_inputs();
        bus.rsp_ready = 1'b1;
        p0 = popped.size();
        n = 0;
        while (popped.size() - p0 < 4 && n < 30) begin
            cycle();
            n++;
        end
        check_eq("credit_pops", 32'(popped.size() - p0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (p0 + i < popped.size())
                check_eq("credit_order", 32'(popped[p0 + i]), 32'(w36[i]));
        end
        check_eq("credit_ready_back", 32'(bus.cmd_ready), 32'd1);

        // Ordered stream of 20 reads with random back-pressure.
        for (int i = 0; i < 16; i++) begin
            wv[i] = DS'($urandom);
            bus.wr_en = 1'b1; bus.wr_addr = AW'(i); bus.wr_data = wv[i];
            cycle();
        end
        idle_inputs();
        max_out = 0;
        p0 = popped.size();
        idx = 0;
        n = 0;
        while ((idx < 20 || bus.busy) && n < 500) begin
            bus.cmd_valid = (idx < 20);
            bus.cmd_addr  = AW'(idx % 16);
            bus.rsp_ready = 1'($urandom_range(0, 1));
            acc = bus.cmd_valid && bus.cmd_ready;
            cycle();
            if (acc) idx++;
            n++;
        end
        check_eq("stream_done", 32'(n < 500), 32'd1);
        check_eq("stream_count", 32'(popped.size() - p0), 32'd20);
        for (int i = 0; i < 20; i++) begin
            if (p0 + i < popped.size())
                check_eq("stream_data", 32'(popped[p0 + i]), 32'(wv[i % 16]));
        end
        check_eq("stream_max_out", 32'(max_out <= int'(DEP)), 32'd1);

        // Fully random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus.wr_en     = 1'($urandom_range(0, 1));
            bus.wr_addr   = AW'($urandom);
            bus.wr_data   = DS'($urandom);
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd_addr  = AW'($urandom);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain("drain_random");

        // Reset in the middle of two in-flight reads.
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_addr = AW'(1);
        cycle();
        bus.cmd_addr = AW'(2);
        cycle();
        idle_inputs();
        repeat (3) cycle();
        check_eq("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        p0 = popped.size();
        repeat (15) cycle();
        check_eq("rst_no_rsp", 32'(popped.size() - p0), 32'd0);
        check_eq("rst_busy_after", 32'(bus.busy), 32'd0);
        check_eq("rst_valid_after", 32'(bus.rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
